// File: rtl/uc_pkg.sv
// Shared definitions for the microcode sequencer: state encoding, register
// indices, ALU op codes and the instruction-field constants it decodes.
package uc_pkg;

  typedef enum logic [4:0] {
    S_FETCH,
    S_DECODE,
    S_EXE_R,
    S_IMM,
    S_EXE_I,
    S_SETHI,
    S_BRANCH,
    S_B1,
    S_B2,
    S_C1,
    S_C2,
    S_C3,
    S_J1,
    S_J2,
    S_J3,
    S_J4,
    S_INCPC,
    S_ILLEGAL
  } ucState_t;

  localparam logic [5:0] REG_LINK = 6'd15;
  localparam logic [5:0] REG_PC   = 6'd32;
  localparam logic [5:0] REG_IR   = 6'd33;
  localparam logic [5:0] REG_T0   = 6'd34;
  localparam logic [5:0] REG_T1   = 6'd35;
  localparam logic [5:0] REG_NONE = 6'd63;

  localparam logic [3:0] ALU_ANDCC  = 4'd0;
  localparam logic [3:0] ALU_ORCC   = 4'd1;
  localparam logic [3:0] ALU_ORNCC  = 4'd2;
  localparam logic [3:0] ALU_ADDCC  = 4'd3;
  localparam logic [3:0] ALU_SRL    = 4'd4;
  localparam logic [3:0] ALU_SEXT13 = 4'd5;
  localparam logic [3:0] ALU_SETHI  = 4'd6;
  localparam logic [3:0] ALU_DISP22 = 4'd7;
  localparam logic [3:0] ALU_DISP30 = 4'd8;
  localparam logic [3:0] ALU_ADD    = 4'd9;
  localparam logic [3:0] ALU_INC4   = 4'd10;
  localparam logic [3:0] ALU_PASS_A = 4'd11;

  localparam logic [1:0] OP_FMT2  = 2'b00;
  localparam logic [1:0] OP_CALL  = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;

  localparam logic [2:0] OP2_BRANCH = 3'b010;
  localparam logic [2:0] OP2_SETHI  = 3'b100;

  localparam logic [5:0] OP3_ADDCC = 6'b010000;
  localparam logic [5:0] OP3_ANDCC = 6'b010001;
  localparam logic [5:0] OP3_ORCC  = 6'b010010;
  localparam logic [5:0] OP3_ORNCC = 6'b010110;
  localparam logic [5:0] OP3_SRL   = 6'b100110;
  localparam logic [5:0] OP3_JMPL  = 6'b111000;

  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;

  // r0 is hard-wired zero, so writes to it are dropped rather than issued.
  function automatic logic [5:0] destReg(input logic [4:0] rd);
    return (rd == 5'd0) ? REG_NONE : {1'b0, rd};
  endfunction

  function automatic logic isAluOp3(input logic [5:0] op3);
    return (op3 == OP3_ADDCC) || (op3 == OP3_ANDCC) || (op3 == OP3_ORCC) ||
           (op3 == OP3_ORNCC) || (op3 == OP3_SRL);
  endfunction

  function automatic logic [3:0] aluForOp3(input logic [5:0] op3);
    case (op3)
      OP3_ADDCC: return ALU_ADDCC;
      OP3_ANDCC: return ALU_ANDCC;
      OP3_ORCC:  return ALU_ORCC;
      OP3_ORNCC: return ALU_ORNCC;
      OP3_SRL:   return ALU_SRL;
      default:   return ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/uc_branch_cond.sv
// Evaluates a branch condition code against the saved PSR {N,Z,V,C};
// unsupported codes are flagged so the sequencer can trap them.
module uc_branch_cond
  import uc_pkg::*;
(
  input  logic [3:0] psr,
  input  logic [3:0] cond,
  output logic       taken,
  output logic       condIllegal
);

  always_comb begin
    taken       = 1'b0;
    condIllegal = 1'b0;
    case (cond)
      COND_BE:   taken = psr[2];
      COND_BCS:  taken = psr[0];
      COND_BNEG: taken = psr[3];
      COND_BVS:  taken = psr[1];
      COND_BA:   taken = 1'b1;
      default:   condIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/uc_sequencer.sv
// Microcode control unit for the uDataPath: runs the fetch/decode/execute
// loop and drives register-write, bus-mux and ALU selections every cycle.
module uc_sequencer
  import uc_pkg::*;
#(
  parameter int DATAWIDTH_DECODER_SELECTION = 6,
  parameter int DATAWIDTH_MUX_SELECTION     = 6,
  parameter int DATAWIDTH_ALU_SELECTION     = 4
)
(
  input  logic                                   UC_SEQUENCER_CLOCK_50,
  input  logic                                   UC_SEQUENCER_Reset_InLow,
  input  logic [1:0]                             UC_SEQUENCER_RegIR_OP,
  input  logic [4:0]                             UC_SEQUENCER_RegIR_RD,
  input  logic [2:0]                             UC_SEQUENCER_RegIR_OP2,
  input  logic [5:0]                             UC_SEQUENCER_RegIR_OP3,
  input  logic [4:0]                             UC_SEQUENCER_RegIR_RS1,
  input  logic                                   UC_SEQUENCER_RegIR_BIT13,
  input  logic [4:0]                             UC_SEQUENCER_RegIR_RS2,
  input  logic                                   UC_SEQUENCER_Negative_InHigh,
  input  logic                                   UC_SEQUENCER_Zero_InHigh,
  input  logic                                   UC_SEQUENCER_Overflow_InHigh,
  input  logic                                   UC_SEQUENCER_Carry_InHigh,
  input  logic                                   UC_SEQUENCER_MemAck_InHigh,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] UC_SEQUENCER_DecoderSelectionWrite_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     UC_SEQUENCER_MUXSelectionBUSA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     UC_SEQUENCER_MUXSelectionBUSB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]     UC_SEQUENCER_ALUSelection_Out,
  output logic                                   UC_SEQUENCER_MemRead_OutHigh,
  output logic                                   UC_SEQUENCER_Illegal_OutHigh
);

  ucState_t   state;
  ucState_t   nextState;
  logic [3:0] psr;
  logic [3:0] flagsNow;
  logic       branchTaken;
  logic       branchIllegal;
  logic [5:0] decSel;
  logic [5:0] muxASel;
  logic [5:0] muxBSel;
  logic [3:0] aluSel;
  logic       memRead;
  logic [5:0] rs1Sel;
  logic [5:0] rs2Sel;

  assign flagsNow = {UC_SEQUENCER_Negative_InHigh, UC_SEQUENCER_Zero_InHigh,
                     UC_SEQUENCER_Overflow_InHigh, UC_SEQUENCER_Carry_InHigh};
  assign rs1Sel   = {1'b0, UC_SEQUENCER_RegIR_RS1};
  assign rs2Sel   = {1'b0, UC_SEQUENCER_RegIR_RS2};

  uc_branch_cond branchCond (
    .psr         (psr),
    .cond        (UC_SEQUENCER_RegIR_RD[3:0]),
    .taken       (branchTaken),
    .condIllegal (branchIllegal)
  );

  // PSR captures the ALU flags only on cycles that issue a condition-code op.
  always_ff @(posedge UC_SEQUENCER_CLOCK_50 or negedge UC_SEQUENCER_Reset_InLow) begin
    if (!UC_SEQUENCER_Reset_InLow) begin
      state <= S_FETCH;
      psr   <= 4'd0;
    end else begin
      state <= nextState;
      if (aluSel <= ALU_ADDCC) begin
        psr <= flagsNow;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      S_FETCH: begin
        if (UC_SEQUENCER_MemAck_InHigh) begin
          nextState = S_DECODE;
        end
      end
      S_DECODE: begin
        nextState = S_ILLEGAL;
        if (UC_SEQUENCER_RegIR_OP == OP_ARITH) begin
          if (isAluOp3(UC_SEQUENCER_RegIR_OP3)) begin
            nextState = UC_SEQUENCER_RegIR_BIT13 ? S_IMM : S_EXE_R;
          end else if ((UC_SEQUENCER_RegIR_OP3 == OP3_JMPL) && UC_SEQUENCER_RegIR_BIT13) begin
            nextState = S_J1;
          end
        end else if (UC_SEQUENCER_RegIR_OP == OP_FMT2) begin
          if (UC_SEQUENCER_RegIR_OP2 == OP2_SETHI) begin
            nextState = S_SETHI;
          end else if (UC_SEQUENCER_RegIR_OP2 == OP2_BRANCH) begin
            nextState = S_BRANCH;
          end
        end else if (UC_SEQUENCER_RegIR_OP == OP_CALL) begin
          nextState = S_C1;
        end
      end
      S_EXE_R:  nextState = S_INCPC;
      S_IMM:    nextState = S_EXE_I;
      S_EXE_I:  nextState = S_INCPC;
      S_SETHI:  nextState = S_INCPC;
      S_BRANCH: begin
        if (branchIllegal) begin
          nextState = S_ILLEGAL;
        end else if (branchTaken) begin
          nextState = S_B1;
        end else begin
          nextState = S_INCPC;
        end
      end
      S_B1:      nextState = S_B2;
      S_B2:      nextState = S_FETCH;
      S_C1:      nextState = S_C2;
      S_C2:      nextState = S_C3;
      S_C3:      nextState = S_FETCH;
      S_J1:      nextState = S_J2;
      S_J2:      nextState = S_J3;
      S_J3:      nextState = S_J4;
      S_J4:      nextState = S_FETCH;
      S_INCPC:   nextState = S_FETCH;
      S_ILLEGAL: nextState = S_ILLEGAL;
      default:   nextState = S_FETCH;
    endcase
  end

  // JMPL parks rs1+disp in T1 before writing rd, so rd == rs1 stays correct.
  always_comb begin
    decSel  = REG_NONE;
    muxASel = 6'd0;
    muxBSel = 6'd0;
    aluSel  = ALU_PASS_A;
    memRead = 1'b0;
    case (state)
      S_FETCH: begin
        muxASel = REG_PC;
        memRead = 1'b1;
        if (UC_SEQUENCER_MemAck_InHigh) begin
          decSel = REG_IR;
        end
      end
      S_EXE_R: begin
        muxASel = rs1Sel;
        muxBSel = rs2Sel;
        aluSel  = aluForOp3(UC_SEQUENCER_RegIR_OP3);
        decSel  = destReg(UC_SEQUENCER_RegIR_RD);
      end
      S_IMM: begin
        muxASel = REG_IR;
        aluSel  = ALU_SEXT13;
        decSel  = REG_T0;
      end
      S_EXE_I: begin
        muxASel = rs1Sel;
        muxBSel = REG_T0;
        aluSel  = aluForOp3(UC_SEQUENCER_RegIR_OP3);
        decSel  = destReg(UC_SEQUENCER_RegIR_RD);
      end
      S_SETHI: begin
        muxASel = REG_IR;
        aluSel  = ALU_SETHI;
        decSel  = destReg(UC_SEQUENCER_RegIR_RD);
      end
      S_B1: begin
        muxASel = REG_IR;
        aluSel  = ALU_DISP22;
        decSel  = REG_T0;
      end
      S_B2, S_C3: begin
        muxASel = REG_PC;
        muxBSel = REG_T0;
        aluSel  = ALU_ADD;
        decSel  = REG_PC;
      end
      S_C1: begin
        muxASel = REG_PC;
        decSel  = REG_LINK;
      end
      S_C2: begin
        muxASel = REG_IR;
        aluSel  = ALU_DISP30;
        decSel  = REG_T0;
      end
      S_J1: begin
        muxASel = REG_IR;
        aluSel  = ALU_SEXT13;
        decSel  = REG_T0;
      end
      S_J2: begin
        muxASel = rs1Sel;
        muxBSel = REG_T0;
        aluSel  = ALU_ADD;
        decSel  = REG_T1;
      end
      S_J3: begin
        muxASel = REG_PC;
        decSel  = destReg(UC_SEQUENCER_RegIR_RD);
      end
      S_J4: begin
        muxASel = REG_T1;
        decSel  = REG_PC;
      end
      S_INCPC: begin
        muxASel = REG_PC;
        aluSel  = ALU_INC4;
        decSel  = REG_PC;
      end
      default: begin
      end
    endcase
  end

  // While reset is held every control output sits at its idle value.
  assign UC_SEQUENCER_DecoderSelectionWrite_Out = UC_SEQUENCER_Reset_InLow ? decSel  : REG_NONE;
  assign UC_SEQUENCER_MUXSelectionBUSA_Out      = UC_SEQUENCER_Reset_InLow ? muxASel : 6'd0;
  assign UC_SEQUENCER_MUXSelectionBUSB_Out      = UC_SEQUENCER_Reset_InLow ? muxBSel : 6'd0;
  assign UC_SEQUENCER_ALUSelection_Out          = UC_SEQUENCER_Reset_InLow ? aluSel  : ALU_PASS_A;
  assign UC_SEQUENCER_MemRead_OutHigh           = UC_SEQUENCER_Reset_InLow & memRead;
  assign UC_SEQUENCER_Illegal_OutHigh           = (state == S_ILLEGAL);

endmodule

// File: tb/tb_uc_sequencer.sv
// Self-checking bench for uc_sequencer: directed scenarios plus random
// instruction streams, compared cycle by cycle against a per-instruction model.
module tb_uc_sequencer;

  logic       clock = 1'b0;
  logic       resetN;
  logic [1:0] irOp;
  logic [4:0] irRd;
  logic [2:0] irOp2;
  logic [5:0] irOp3;
  logic [4:0] irRs1;
  logic       irBit13;
  logic [4:0] irRs2;
  logic       flagN, flagZ, flagV, flagC;
  logic       memAck;
  logic [5:0] decSel;
  logic [5:0] muxA;
  logic [5:0] muxB;
  logic [3:0] aluSel;
  logic       memRead;
  logic       illegal;

  int compared   = 0;
  int mismatched = 0;

  bit         mN, mZ, mV, mC;
  bit         useFixed;
  logic [3:0] fixedFlags;
  logic [3:0] curFlags;
  bit         wentIllegal;

  typedef struct packed {
    logic [5:0] dec;
    logic [5:0] a;
    logic [5:0] b;
    logic [3:0] alu;
    logic       mr;
    logic       ill;
  } obs_t;

  always #5 clock = ~clock;

  uc_sequencer dut (
    .UC_SEQUENCER_CLOCK_50                  (clock),
    .UC_SEQUENCER_Reset_InLow               (resetN),
    .UC_SEQUENCER_RegIR_OP                  (irOp),
    .UC_SEQUENCER_RegIR_RD                  (irRd),
    .UC_SEQUENCER_RegIR_OP2                 (irOp2),
    .UC_SEQUENCER_RegIR_OP3                 (irOp3),
    .UC_SEQUENCER_RegIR_RS1                 (irRs1),
    .UC_SEQUENCER_RegIR_BIT13               (irBit13),
    .UC_SEQUENCER_RegIR_RS2                 (irRs2),
    .UC_SEQUENCER_Negative_InHigh           (flagN),
    .UC_SEQUENCER_Zero_InHigh               (flagZ),
    .UC_SEQUENCER_Overflow_InHigh           (flagV),
    .UC_SEQUENCER_Carry_InHigh              (flagC),
    .UC_SEQUENCER_MemAck_InHigh             (memAck),
    .UC_SEQUENCER_DecoderSelectionWrite_Out (decSel),
    .UC_SEQUENCER_MUXSelectionBUSA_Out      (muxA),
    .UC_SEQUENCER_MUXSelectionBUSB_Out      (muxB),
    .UC_SEQUENCER_ALUSelection_Out          (aluSel),
    .UC_SEQUENCER_MemRead_OutHigh           (memRead),
    .UC_SEQUENCER_Illegal_OutHigh           (illegal)
  );

  function automatic obs_t mk(input int dec, input int a, input int b, input int alu,
                              input bit mr, input bit ill);
    obs_t r;
    r.dec = 6'(dec);
    r.a   = 6'(a);
    r.b   = 6'(b);
    r.alu = 4'(alu);
    r.mr  = mr;
    r.ill = ill;
    return r;
  endfunction

  function automatic int dst(input logic [4:0] rd);
    return (rd == 5'd0) ? 63 : int'(rd);
  endfunction

  // -1 marks an OP3 that is not one of the five ALU instructions.
  function automatic int aluCode(input logic [5:0] op3);
    case (op3)
      6'b010001: return 0;
      6'b010010: return 1;
      6'b010110: return 2;
      6'b010000: return 3;
      6'b100110: return 4;
      default:   return -1;
    endcase
  endfunction

  task automatic applyStimulus(input bit ack);
    curFlags = useFixed ? fixedFlags : 4'($urandom_range(0, 15));
    {flagN, flagZ, flagV, flagC} = curFlags;
    memAck = ack;
  endtask

  task automatic checkOutput(input string tag, input obs_t want);
    obs_t got;
    got = {decSel, muxA, muxB, aluSel, memRead, illegal};
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("[TB] FAIL %s: got dec=%0d A=%0d B=%0d alu=%0d memRead=%0b ill=%0b, expected dec=%0d A=%0d B=%0d alu=%0d memRead=%0b ill=%0b",
             tag, got.dec, got.a, got.b, got.alu, got.mr, got.ill,
             want.dec, want.a, want.b, want.alu, want.mr, want.ill);
    end
  endtask

  task automatic stepCycle(input bit ack, input string tag, input obs_t want, input bit advance);
    applyStimulus(ack);
    @(negedge clock);
    checkOutput(tag, want);
    if (advance) begin
      if (want.alu <= 4'd3) {mN, mZ, mV, mC} = curFlags;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic doReset(input string tag);
    resetN = 1'b0;
    memAck = 1'b0;
    #1;
    compared++;
    assert ({decSel, illegal} === {6'd63, 1'b0}) else begin
      mismatched++;
      $error("[TB] FAIL %s: during reset got dec=%0d ill=%0b, expected dec=63 ill=0",
             tag, decSel, illegal);
    end
    @(posedge clock);
    #4;
    resetN = 1'b1;
    {mN, mZ, mV, mC} = 4'b0000;
    @(posedge clock);
    #1;
  endtask

  // Expected cycles for one instruction are derived from its class alone.
  task automatic runInstr(input logic [1:0] op, input logic [4:0] rd, input logic [2:0] op2,
                          input logic [5:0] op3, input logic [4:0] rs1, input logic bit13,
                          input logic [4:0] rs2, input int ackDelay, input int abortAfter,
                          input string tag, output bit toIllegal);
    obs_t rows[$];
    obs_t incPc;
    int   ac;
    bit   taken;
    bit   badCond;
    irOp = op; irRd = rd; irOp2 = op2; irOp3 = op3;
    irRs1 = rs1; irBit13 = bit13; irRs2 = rs2;
    toIllegal = 1'b0;
    incPc = mk(32, 32, 0, 10, 0, 0);
    ac = aluCode(op3);
    for (int i = 0; i < ackDelay; i++) stepCycle(1'b0, {tag, " fetch-wait"}, mk(63, 32, 0, 11, 1, 0), 1'b1);
    stepCycle(1'b1, {tag, " fetch-ack"}, mk(33, 32, 0, 11, 1, 0), 1'b1);
    stepCycle(1'($urandom_range(0, 1)), {tag, " decode"}, mk(63, 0, 0, 11, 0, 0), 1'b1);
    if (op == 2'b10 && ac >= 0 && !bit13) begin
      rows.push_back(mk(dst(rd), rs1, rs2, ac, 0, 0));
      rows.push_back(incPc);
    end else if (op == 2'b10 && ac >= 0) begin
      rows.push_back(mk(34, 33, 0, 5, 0, 0));
      rows.push_back(mk(dst(rd), rs1, 34, ac, 0, 0));
      rows.push_back(incPc);
    end else if (op == 2'b10 && op3 == 6'b111000 && bit13) begin
      rows.push_back(mk(34, 33, 0, 5, 0, 0));
      rows.push_back(mk(35, rs1, 34, 9, 0, 0));
      rows.push_back(mk(dst(rd), 32, 0, 11, 0, 0));
      rows.push_back(mk(32, 35, 0, 11, 0, 0));
    end else if (op == 2'b00 && op2 == 3'b100) begin
      rows.push_back(mk(dst(rd), 33, 0, 6, 0, 0));
      rows.push_back(incPc);
    end else if (op == 2'b00 && op2 == 3'b010) begin
      rows.push_back(mk(63, 0, 0, 11, 0, 0));
      badCond = 1'b0;
      taken   = 1'b0;
      case (rd[3:0])
        4'd1:    taken = mZ;
        4'd5:    taken = mC;
        4'd6:    taken = mN;
        4'd7:    taken = mV;
        4'd8:    taken = 1'b1;
        default: badCond = 1'b1;
      endcase
      if (badCond) begin
        toIllegal = 1'b1;
      end else if (taken) begin
        rows.push_back(mk(34, 33, 0, 7, 0, 0));
        rows.push_back(mk(32, 32, 34, 9, 0, 0));
      end else begin
        rows.push_back(incPc);
      end
    end else if (op == 2'b01) begin
      rows.push_back(mk(15, 32, 0, 11, 0, 0));
      rows.push_back(mk(34, 33, 0, 8, 0, 0));
      rows.push_back(mk(32, 32, 34, 9, 0, 0));
    end else begin
      toIllegal = 1'b1;
    end
    foreach (rows[i]) begin
      if (abortAfter == i + 1) begin
        stepCycle(1'($urandom_range(0, 1)), {tag, " exec"}, rows[i], 1'b0);
        return;
      end
      stepCycle(1'($urandom_range(0, 1)), {tag, " exec"}, rows[i], 1'b1);
    end
  endtask

  task automatic holdIllegal(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) stepCycle(i[0], {tag, " illegal-hold"}, mk(63, 0, 0, 11, 0, 1), 1'b1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] aluOps[5];
    logic [3:0] goodConds[5];
    int         sel;
    aluOps    = '{6'b010000, 6'b010001, 6'b010010, 6'b010110, 6'b100110};
    goodConds = '{4'd1, 4'd5, 4'd6, 4'd7, 4'd8};
    irOp = 0; irRd = 0; irOp2 = 0; irOp3 = 0; irRs1 = 0; irBit13 = 0; irRs2 = 0;
    flagN = 0; flagZ = 0; flagV = 0; flagC = 0; memAck = 0;
    useFixed = 1'b1;
    fixedFlags = 4'b0100;

    doReset("power-on");
    runInstr(2'b10, 5'd3, 3'd0, 6'b010000, 5'd1, 1'b0, 5'd2, 0, 0, "ADDCC set Z", wentIllegal);
    runInstr(2'b01, 5'd7, 3'd2, 6'd9, 5'd4, 1'b1, 5'd6, 1, 2, "CALL aborted", wentIllegal);
    doReset("mid-C2");
    runInstr(2'b00, 5'd1, 3'b010, 6'd0, 5'd0, 1'b0, 5'd0, 0, 0, "BE after reset", wentIllegal);
    runInstr(2'b10, 5'd3, 3'd0, 6'b010000, 5'd1, 1'b0, 5'd2, 3, 0, "ADDCC r3,r1,r2", wentIllegal);
    runInstr(2'b00, 5'd1, 3'b010, 6'd0, 5'd0, 1'b0, 5'd0, 1, 0, "BE taken", wentIllegal);
    useFixed = 1'b0;
    runInstr(2'b10, 5'd0, 3'd0, 6'b010010, 5'd7, 1'b1, 5'd0, 2, 0, "ORCC imm rd0", wentIllegal);
    runInstr(2'b00, 5'd3, 3'b010, 6'd0, 5'd0, 1'b0, 5'd0, 0, 0, "bad cond", wentIllegal);
    holdIllegal(10, "bad cond");
    doReset("after illegal");
    runInstr(2'b01, 5'd9, 3'd5, 6'd1, 5'd2, 1'b0, 5'd3, 1, 0, "CALL", wentIllegal);
    runInstr(2'b10, 5'd5, 3'd0, 6'b111000, 5'd5, 1'b1, 5'd8, 0, 0, "JMPL r5", wentIllegal);
    runInstr(2'b10, 5'd5, 3'd0, 6'b111000, 5'd5, 1'b0, 5'd8, 0, 0, "JMPL reg form", wentIllegal);
    holdIllegal(3, "JMPL reg form");
    doReset("after JMPL trap");
    runInstr(2'b00, 5'd9, 3'b100, 6'd0, 5'd0, 1'b0, 5'd0, 2, 0, "SETHI", wentIllegal);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      irRd  = 5'($urandom_range(0, 31));
      irRs1 = 5'($urandom_range(0, 31));
      irRs2 = 5'($urandom_range(0, 31));
      case (sel)
        0, 1, 2, 3, 4:
          runInstr(2'b10, irRd, 3'($urandom), aluOps[$urandom_range(0, 4)], irRs1,
                   1'($urandom_range(0, 1)), irRs2, $urandom_range(0, 3), 0, "rand ALU", wentIllegal);
        5:
          runInstr(2'b00, irRd, 3'b100, 6'($urandom), irRs1, 1'($urandom_range(0, 1)), irRs2,
                   $urandom_range(0, 3), 0, "rand SETHI", wentIllegal);
        6:
          runInstr(2'b00, ($urandom_range(0, 3) != 0) ? {1'($urandom), goodConds[$urandom_range(0, 4)]} : irRd,
                   3'b010, 6'($urandom), irRs1, 1'($urandom_range(0, 1)), irRs2,
                   $urandom_range(0, 3), 0, "rand branch", wentIllegal);
        7:
          runInstr(2'b01, irRd, 3'($urandom), 6'($urandom), irRs1, 1'($urandom_range(0, 1)), irRs2,
                   $urandom_range(0, 3), 0, "rand CALL", wentIllegal);
        8:
          runInstr(2'b10, irRd, 3'($urandom), 6'b111000, irRs1, ($urandom_range(0, 3) != 0), irRs2,
                   $urandom_range(0, 3), 0, "rand JMPL", wentIllegal);
        default:
          runInstr(2'($urandom), irRd, 3'($urandom), 6'($urandom), irRs1, 1'($urandom_range(0, 1)), irRs2,
                   $urandom_range(0, 3), 0, "rand any", wentIllegal);
      endcase
      if (wentIllegal) begin
        holdIllegal(3, "rand");
        doReset("rand trap");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
